clock_mode_ctrl: RTL
====================

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 Parameter TIMEOUT_SEC, default 10, is the idle seconds after which any set mode returns to RUN.
REQ-002 Parameter RING_SEC, default 60, is the maximum alarm ring length in seconds.
REQ-003 clk  in  1  system clock; the only clock in the block.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 tick_1hz  in  1  one-clk pulse per second.
REQ-006 btn_mode  in  1  debounced, synchronized mode-key level.
REQ-007 btn_inc  in  1  debounced, synchronized increment-key level.
REQ-008 alarm_en  in  1  alarm arm switch.
REQ-009 cur_h1, cur_h0, cur_m1, cur_m0  in  4 each  current time, BCD, hours 00-23 and minutes 00-59.
REQ-010 set_inc_hour, set_inc_min  out  1 each  one-clk increment pulses to the time counters.
REQ-011 hold_sec  out  1  holds and clears the seconds counter.
REQ-012 alm_h1, alm_h0, alm_m1, alm_m0  out  4 each  registered alarm time, BCD.
REQ-013 mode  out  3  current state code.
REQ-014 blink_sel  out  2  digit blink select: 0 none, 1 hours, 2 minutes.
REQ-015 show_alarm  out  1  display shows alarm time instead of current time.
REQ-016 bee_en, bee_tone  out  1 each  beeper enable and tone select.

Function
REQ-017 The block SHALL detect rising edges of btn_mode and btn_inc with a registered previous sample, which resets to 0.
REQ-018 The FSM SHALL use these codes: RUN=0, SET_HOUR=1, SET_MIN=2, ALM_HOUR=3, ALM_MIN=4, RING=5.
REQ-019 A mode edge SHALL advance the state RUN -> SET_HOUR -> SET_MIN -> ALM_HOUR -> ALM_MIN -> RUN, one step per edge.
REQ-020 An inc edge SHALL produce the following one-clk pulse on the next clk edge after the button edge is detected:
- in SET_HOUR: set_inc_hour;
- in SET_MIN: set_inc_min;
- in ALM_HOUR: alarm hour +1, wrapping 23->00;
- in ALM_MIN: alarm minute +1, wrapping 59->00.
REQ-021 An inc edge in RUN SHALL be ignored.
REQ-022 If mode and inc edges occur in the same cycle, mode SHALL win and the inc edge SHALL be dropped.
REQ-023 In set states, an idle counter SHALL count tick_1hz; any button edge SHALL clear it, and reaching TIMEOUT_SEC SHALL force RUN.
REQ-024 In RUN, when alarm_en=1 and the current time equals the alarm time, the rising edge of that match SHALL enter RING, so the alarm triggers at most once per match minute.
REQ-025 A match that occurs while in any set state SHALL NOT trigger RING.
REQ-026 In RING:
- bee_en=1;
- bee_tone SHALL toggle on each tick_1hz.
REQ-027 RING SHALL return to RUN on whichever of these comes first:
- any button edge (the edge is consumed, with no mode advance and no increment);
- alarm_en=0;
- RING_SEC ticks.
REQ-028 hold_sec SHALL be 1 only in SET_HOUR and SET_MIN.
REQ-029 blink_sel SHALL be 1 in SET_HOUR and ALM_HOUR, 2 in SET_MIN and ALM_MIN, and 0 otherwise.
REQ-030 show_alarm SHALL be 1 only in ALM_HOUR and ALM_MIN.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While rst_n=0, the state SHALL be RUN, all outputs 0, the alarm time 00:00, and all counters and edge registers 0.
REQ-033 Reset asserted mid-RING or mid-set SHALL abort immediately, with no pending pulse emitted after release.

Structure
REQ-034 The state codes, blink_sel codes and BCD limits (23, 59) SHALL be defined in a shared package, clock_pkg.
REQ-035 One sub-module, bcd2_wrap_inc, SHALL implement the two-digit BCD increment with a wrap maximum; it is instantiated once for the alarm hour and once for the alarm minute.

Verification
REQ-036 Reset, then 5 mode edges -> mode sequence 1,2,3,4,0; blink_sel sequence 1,2,1,2,0; hold_sec=1 only at modes 1 and 2.
REQ-037 In ALM_HOUR, 24 inc edges -> alm hour 01..23 then 00.
REQ-038 In ALM_MIN, 60 inc edges -> alm minute wraps to 00.
REQ-039 Alarm 07:30, alarm_en=1, cur steps 07:29->07:30 -> mode=5, bee_en=1, bee_tone toggles per tick.
REQ-040 In the same RING, after 60 ticks with no button -> mode=0, bee_en=0, and no re-trigger while cur remains 07:30.
REQ-041 In SET_MIN, a simultaneous mode+inc edge -> mode=3, no set_inc_min pulse.
REQ-042 In SET_MIN, 10 ticks with no keys -> mode=0.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared definitions for the alarm-clock mode controller:
//                FSM state codes, digit-blink select codes and the BCD wrap
//                limits for hours (23) and minutes (59).
//  Contents    : mode_e, blink_e, c_* limits, blink_for(), hold_for()
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  typedef enum logic [2:0] {
    MODE_RUN      = 3'd0,
    MODE_SET_HOUR = 3'd1,
    MODE_SET_MIN  = 3'd2,
    MODE_ALM_HOUR = 3'd3,
    MODE_ALM_MIN  = 3'd4,
    MODE_RING     = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    BLINK_NONE = 2'd0,
    BLINK_HOUR = 2'd1,
    BLINK_MIN  = 2'd2
  } blink_e;

  localparam logic [3:0] c_HOUR_MAX_TENS = 4'd2;
  localparam logic [3:0] c_HOUR_MAX_ONES = 4'd3;
  localparam logic [3:0] c_MIN_MAX_TENS  = 4'd5;
  localparam logic [3:0] c_MIN_MAX_ONES  = 4'd9;

  function automatic blink_e blink_for(input mode_e m);
    blink_e b;
    case (m)
      MODE_SET_HOUR, MODE_ALM_HOUR: b = BLINK_HOUR;
      MODE_SET_MIN,  MODE_ALM_MIN:  b = BLINK_MIN;
      default:                      b = BLINK_NONE;
    endcase
    return b;
  endfunction

  // Seconds are frozen only while the real time is being edited.
  function automatic logic hold_for(input mode_e m);
    return (m == MODE_SET_HOUR) || (m == MODE_SET_MIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_wrap_inc.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2_wrap_inc
//  Description : Combinational two-digit BCD increment. The value MAX_TENS:
//                MAX_ONES wraps to 00; otherwise ones roll 9 -> 0 with a
//                carry into the tens digit.
//  Ports       : i_tens, i_ones  - current BCD digits
//                o_tens, o_ones  - incremented BCD digits
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd2_wrap_inc #(
  parameter logic [3:0] MAX_TENS = 4'd5,
  parameter logic [3:0] MAX_ONES = 4'd9
) (
  input  logic [3:0] i_tens,
  input  logic [3:0] i_ones,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  always_comb begin
    o_tens = i_tens;
    o_ones = i_ones + 4'd1;
    if ((i_tens == MAX_TENS) && (i_ones == MAX_ONES)) begin
      o_tens = 4'd0;
      o_ones = 4'd0;
    end else if (i_ones == 4'd9) begin
      o_tens = i_tens + 4'd1;
      o_ones = 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_mode_ctrl
//  Description : Mode/set/alarm controller for a 24h BCD clock. Steps through
//                set and alarm-set modes on the mode key, issues increment
//                pulses on the inc key, keeps the alarm time, rings the
//                beeper on an alarm match and times out idle set modes.
//  Ports       : clk, rst_n (async, active-low), tick_1hz, btn_mode,
//                btn_inc, alarm_en, cur_h1/h0/m1/m0 (BCD current time)
//                -> set_inc_hour, set_inc_min, hold_sec, alm_h1/h0/m1/m0,
//                   mode, blink_sel, show_alarm, bee_en, bee_tone
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10,
  parameter int RING_SEC    = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_en,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic       set_inc_hour,
  output logic       set_inc_min,
  output logic       hold_sec,
  output logic [3:0] alm_h1,
  output logic [3:0] alm_h0,
  output logic [3:0] alm_m1,
  output logic [3:0] alm_m0,
  output logic [2:0] mode,
  output logic [1:0] blink_sel,
  output logic       show_alarm,
  output logic       bee_en,
  output logic       bee_tone
);

  localparam int c_IDLE_W = $clog2(TIMEOUT_SEC + 1);
  localparam int c_RING_W = $clog2(RING_SEC + 1);

  mode_e               state_q, state_d;
  logic                mode_prev_q, inc_prev_q, match_prev_q;
  logic [c_IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [c_RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [3:0]          alm_h1_q, alm_h0_q, alm_m1_q, alm_m0_q;
  logic [3:0]          alm_h1_d, alm_h0_d, alm_m1_d, alm_m0_d;
  logic                inc_hour_q, inc_hour_d, inc_min_q, inc_min_d;
  logic                bee_tone_q, bee_tone_d;
  logic                hold_q, bee_en_q, show_q;
  blink_e              blink_q;

  logic       w_mode_edge, w_inc_edge, w_any_edge;
  logic       w_match, w_match_rise;
  logic [3:0] w_hr_tens, w_hr_ones, w_mn_tens, w_mn_ones;

  assign w_mode_edge = btn_mode & ~mode_prev_q;
  assign w_inc_edge  = btn_inc  & ~inc_prev_q;
  assign w_any_edge  = w_mode_edge | w_inc_edge;

  // The match is tracked in every state, so a match that starts while a set
  // mode is active is already "old" when RUN resumes and will not ring.
  assign w_match      = alarm_en &&
                        ({cur_h1, cur_h0, cur_m1, cur_m0} ==
                         {alm_h1_q, alm_h0_q, alm_m1_q, alm_m0_q});
  assign w_match_rise = w_match & ~match_prev_q;

  bcd2_wrap_inc #(
    .MAX_TENS (c_HOUR_MAX_TENS),
    .MAX_ONES (c_HOUR_MAX_ONES)
  ) u_hour_inc (
    .i_tens (alm_h1_q),
    .i_ones (alm_h0_q),
    .o_tens (w_hr_tens),
    .o_ones (w_hr_ones)
  );

  bcd2_wrap_inc #(
    .MAX_TENS (c_MIN_MAX_TENS),
    .MAX_ONES (c_MIN_MAX_ONES)
  ) u_min_inc (
    .i_tens (alm_m1_q),
    .i_ones (alm_m0_q),
    .o_tens (w_mn_tens),
    .o_ones (w_mn_ones)
  );

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    ring_cnt_d = '0;
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    alm_h1_d   = alm_h1_q;
    alm_h0_d   = alm_h0_q;
    alm_m1_d   = alm_m1_q;
    alm_m0_d   = alm_m0_q;
    bee_tone_d = 1'b0;

    case (state_q)
      MODE_RUN: begin
        // An alarm starting in the same cycle as a mode key wins, so the
        // alarm minute is never lost to a coincident key press.
        if (w_match_rise) begin
          state_d = MODE_RING;
        end else if (w_mode_edge) begin
          state_d = MODE_SET_HOUR;
        end
      end

      MODE_SET_HOUR, MODE_SET_MIN, MODE_ALM_HOUR, MODE_ALM_MIN: begin
        if (w_mode_edge) begin
          // Mode beats a simultaneous inc edge; the inc is dropped.
          case (state_q)
            MODE_SET_HOUR: state_d = MODE_SET_MIN;
            MODE_SET_MIN:  state_d = MODE_ALM_HOUR;
            MODE_ALM_HOUR: state_d = MODE_ALM_MIN;
            default:       state_d = MODE_RUN;
          endcase
        end else if (w_inc_edge) begin
          case (state_q)
            MODE_SET_HOUR: inc_hour_d = 1'b1;
            MODE_SET_MIN:  inc_min_d  = 1'b1;
            MODE_ALM_HOUR: begin
              alm_h1_d = w_hr_tens;
              alm_h0_d = w_hr_ones;
            end
            default: begin
              alm_m1_d = w_mn_tens;
              alm_m0_d = w_mn_ones;
            end
          endcase
        end else if (tick_1hz) begin
          if (idle_cnt_q == c_IDLE_W'(TIMEOUT_SEC - 1)) begin
            state_d = MODE_RUN;
          end else begin
            idle_cnt_d = idle_cnt_q + c_IDLE_W'(1);
          end
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
      end

      MODE_RING: begin
        if (w_any_edge || !alarm_en) begin
          // Edge is swallowed: no mode step, no increment.
          state_d = MODE_RUN;
        end else if (tick_1hz) begin
          if (ring_cnt_q == c_RING_W'(RING_SEC - 1)) begin
            state_d = MODE_RUN;
          end else begin
            ring_cnt_d = ring_cnt_q + c_RING_W'(1);
            bee_tone_d = ~bee_tone_q;
          end
        end else begin
          ring_cnt_d = ring_cnt_q;
          bee_tone_d = bee_tone_q;
        end
      end

      default: state_d = MODE_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MODE_RUN;
      mode_prev_q  <= 1'b0;
      inc_prev_q   <= 1'b0;
      match_prev_q <= 1'b0;
      idle_cnt_q   <= '0;
      ring_cnt_q   <= '0;
      alm_h1_q     <= 4'd0;
      alm_h0_q     <= 4'd0;
      alm_m1_q     <= 4'd0;
      alm_m0_q     <= 4'd0;
      inc_hour_q   <= 1'b0;
      inc_min_q    <= 1'b0;
      bee_tone_q   <= 1'b0;
      hold_q       <= 1'b0;
      bee_en_q     <= 1'b0;
      show_q       <= 1'b0;
      blink_q      <= BLINK_NONE;
    end else begin
      state_q      <= state_d;
      mode_prev_q  <= btn_mode;
      inc_prev_q   <= btn_inc;
      match_prev_q <= w_match;
      idle_cnt_q   <= idle_cnt_d;
      ring_cnt_q   <= ring_cnt_d;
      alm_h1_q     <= alm_h1_d;
      alm_h0_q     <= alm_h0_d;
      alm_m1_q     <= alm_m1_d;
      alm_m0_q     <= alm_m0_d;
      inc_hour_q   <= inc_hour_d;
      inc_min_q    <= inc_min_d;
      bee_tone_q   <= bee_tone_d;
      // Decoded outputs are registered from the next state so they change
      // on the same edge as mode.
      hold_q       <= hold_for(state_d);
      bee_en_q     <= (state_d == MODE_RING);
      show_q       <= (state_d == MODE_ALM_HOUR) || (state_d == MODE_ALM_MIN);
      blink_q      <= blink_for(state_d);
    end
  end

  assign mode         = state_q;
  assign set_inc_hour = inc_hour_q;
  assign set_inc_min  = inc_min_q;
  assign hold_sec     = hold_q;
  assign alm_h1       = alm_h1_q;
  assign alm_h0       = alm_h0_q;
  assign alm_m1       = alm_m1_q;
  assign alm_m0       = alm_m0_q;
  assign blink_sel    = blink_q;
  assign show_alarm   = show_q;
  assign bee_en       = bee_en_q;
  assign bee_tone     = bee_tone_q;

endmodule
`default_nettype wire
